mdu_hilo: RTL and testbench

//  Multi-cycle multiply/divide unit beside the single-cycle ALU in execute.

---
 rtl/mdu_hilo_pkg.sv | 14 +
 rtl/mdu_hilo_if.sv | 16 +
 rtl/mdu_hilo_div_step.sv | 16 +
 rtl/mdu_hilo.sv | 103 ++++++++++
 tb/tb_mdu_hilo.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo_pkg: shared types, constants and helpers for the multiply/divide unit
package mdu_hilo_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [2:0] {
        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO
    } mdu_op_t;
    // State names carry an S_ infix because MDU_DIV is already taken by the op enum.
    typedef enum logic [1:0] {MDU_S_IDLE, MDU_S_MUL, MDU_S_DIV, MDU_S_FIX} mdu_state_t;
    localparam int DIV_ITERS = 32;
    // Magnitude of a word; 0x8000_0000 maps to itself, which is the correct unsigned value.
    function automatic word_t mag(word_t x, logic sgn);
        return sgn && x[31] ? -x : x;
    endfunction
endpackage

// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: request/result bundle between execute and the multiply/divide unit
//   master drives flush, valid, op, a, b; slave drives busy, done, hi, lo
interface mdu_hilo_if;
    import mdu_hilo_pkg::*;
    logic    flush;
    logic    valid;
    mdu_op_t op;
    word_t   a;
    word_t   b;
    logic    busy;
    logic    done;
    word_t   hi;
    word_t   lo;
    modport master(output flush, valid, op, a, b, input busy, done, hi, lo);
    modport slave(input flush, valid, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_hilo_div_step.sv
// mdu_hilo_div_step: one combinational restoring-division step
//   rem/quo/divisor in, rem_next/quo_next out; the dividend is shifted out of quo's MSB
module mdu_hilo_div_step (
    input  logic [32:0] rem,
    input  logic [31:0] quo,
    input  logic [32:0] divisor,
    output logic [32:0] rem_next,
    output logic [31:0] quo_next
);
    logic [33:0] sh;
    logic        ge;
    assign sh       = {rem, quo[31]};
    assign ge       = sh >= {1'b0, divisor};
    assign rem_next = 33'(ge ? sh - {1'b0, divisor} : sh);
    assign quo_next = {quo[30:0], ge};
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle MULT/MULTU/DIV/DIVU into HI/LO, plus single-cycle MTHI/MTLO
//   clk, reset (sync, active-high); bus.slave: flush, valid, op, a, b in; busy, done, hi, lo out
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input logic       clk,
    input logic       reset,
    mdu_hilo_if.slave bus
);
    mdu_state_t  state, state_next;
    logic [4:0]  cnt;
    logic        setup, sgn_q, done_q, accept, is_mul, is_div, neg_q, neg_r;
    word_t       a_q, b_q, quo, quo_next, hi_q, lo_q;
    logic [32:0] rem, rem_next, divisor;
    logic [63:0] prod;
    assign accept = bus.valid && state == MDU_S_IDLE && !bus.flush;
    assign is_mul = bus.op == MDU_MULT || bus.op == MDU_MULTU;
    assign is_div = bus.op == MDU_DIV || bus.op == MDU_DIVU;
    assign neg_q  = sgn_q & (a_q[31] ^ b_q[31]);
    assign neg_r  = sgn_q & a_q[31];
    // Sign-extending to 64 bits makes the truncated unsigned product correct for both MULT and MULTU.
    assign prod   = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};
    mdu_hilo_div_step u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (divisor),
        .rem_next(rem_next),
        .quo_next(quo_next)
    );
    always_ff @(posedge clk) state <= reset ? MDU_S_IDLE : state_next;
    always_comb begin
        state_next = state;
        case (state)
            MDU_S_IDLE: state_next = !accept ? MDU_S_IDLE : is_mul ? MDU_S_MUL : is_div ? MDU_S_DIV : MDU_S_IDLE;
            MDU_S_MUL:  state_next = cnt == '0 ? MDU_S_IDLE : MDU_S_MUL;
            MDU_S_DIV:  state_next = !setup && cnt == '0 ? MDU_S_FIX : MDU_S_DIV;
            default:    state_next = MDU_S_IDLE;
        endcase
        if (bus.flush) state_next = MDU_S_IDLE;
    end
    always_comb begin
        bus.busy = state != MDU_S_IDLE;
        bus.done = done_q;
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            setup   <= 1'b0;
            sgn_q   <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (!bus.flush) begin
                case (state)
                    MDU_S_IDLE: if (accept) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        sgn_q <= bus.op == MDU_MULT || bus.op == MDU_DIV;
                        cnt   <= is_mul ? 5'(MUL_LAT - 1) : 5'(DIV_ITERS - 1);
                        setup <= 1'b1;
                        if (bus.op == MDU_MTHI) hi_q <= bus.a;
                        if (bus.op == MDU_MTLO) lo_q <= bus.a;
                    end
                    MDU_S_MUL: begin
                        cnt <= cnt - 5'd1;
                        if (cnt == '0) begin
                            {hi_q, lo_q} <= prod;
                            done_q       <= 1'b1;
                        end
                    end
                    // First DIV cycle is the setup: magnitudes are loaded, then 32 steps follow.
                    MDU_S_DIV: if (setup) begin
                        setup   <= 1'b0;
                        rem     <= '0;
                        quo     <= mag(a_q, sgn_q);
                        divisor <= {1'b0, mag(b_q, sgn_q)};
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt - 5'd1;
                    end
                    // Divide by zero bypasses the sign fix and reports the raw dividend in HI.
                    MDU_S_FIX: begin
                        lo_q   <= b_q == '0 ? '1 : neg_q ? -quo : quo;
                        hi_q   <= b_q == '0 ? a_q : neg_r ? -rem[31:0] : rem[31:0];
                        done_q <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: scoreboard bench for mdu_hilo; expected HI/LO/latency queued at issue, checked at done
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 34;
    typedef struct {
        word_t hi;
        word_t lo;
        int    lat;
    } exp_t;
    logic  clk;
    logic  reset;
    int    vectors;
    int    miscompares;
    word_t mdl_hi;
    word_t mdl_lo;
    exp_t  sb[$];
    mdu_hilo_if bus ();
    mdu_hilo #(.MUL_LAT(MUL_LAT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    function automatic logic [63:0] model(mdu_op_t op, word_t a, word_t b);
        longint          sa, sb2;
        longint unsigned ua, ub;
        int              da, db;
        sa = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        da = a;
        db = b;
        case (op)
            MDU_MULT:  return 64'(sa * sb2);
            MDU_MULTU: return 64'(ua * ub);
            MDU_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(da % db), 32'(da / db)};
            end
            MDU_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction
    task automatic issue(input mdu_op_t op, input word_t a, input word_t b, input bit push);
        logic [63:0] r;
        if (push) begin
            r = model(op, a, b);
            sb.push_back('{r[63:32], r[31:0], (op == MDU_MULT || op == MDU_MULTU) ? MUL_LAT : DIV_LAT});
        end
        @(negedge clk);
        bus.valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
    endtask
    task automatic wait_done(input int from, output int cyc);
        cyc = -1;
        for (int n = from + 1; n <= from + 60; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                cyc = n;
                break;
            end
        end
    endtask
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors += 4;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b want 0", bus.done); end
        if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL reset hi: got %h want 0", bus.hi); end
        if (bus.lo !== 32'd0) begin miscompares++; $display("FAIL reset lo: got %h want 0", bus.lo); end
        @(negedge clk);
        reset = 1'b0;
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
    endtask
    task automatic test_mul();
        mdu_op_t ops[4] = '{MDU_MULT, MDU_MULTU, MDU_MULT, MDU_MULTU};
        word_t   av[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
        word_t   bv[4] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'h9ABC_DEF0};
        int      c;
        exp_t    e;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], av[i], bv[i], 1'b1);
            vectors++;
            if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL mul[%0d] busy after accept: got %b want 1", i, bus.busy); end
            wait_done(0, c);
            e = sb.pop_front();
            vectors += 3;
            if (c !== e.lat) begin miscompares++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, c, e.lat); end
            if (bus.hi !== e.hi) begin miscompares++; $display("FAIL mul[%0d] hi: got %h want %h", i, bus.hi, e.hi); end
            if (bus.lo !== e.lo) begin miscompares++; $display("FAIL mul[%0d] lo: got %h want %h", i, bus.lo, e.lo); end
            mdl_hi = e.hi;
            mdl_lo = e.lo;
            @(posedge clk);
            #1;
            vectors++;
            if (bus.done !== 1'b0) begin miscompares++; $display("FAIL mul[%0d] done pulse width: got %b want 0", i, bus.done); end
        end
    endtask
    task automatic test_div();
        mdu_op_t ops[9] = '{MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIV, MDU_DIVU, MDU_DIVU, MDU_DIV, MDU_DIV, MDU_DIV};
        word_t   av[9] = '{32'hFFFF_FFF9, 32'd7, 32'd7, 32'hFFFF_FF9C, 32'hFFFF_FFFF,
                           32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
        word_t   bv[9] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd10,
                           32'd0, 32'd0, 32'hFFFF_FFFF, 32'd2};
        int      c;
        exp_t    e;
        for (int i = 0; i < 9; i++) begin
            issue(ops[i], av[i], bv[i], 1'b1);
            wait_done(0, c);
            e = sb.pop_front();
            vectors += 3;
            if (c !== e.lat) begin miscompares++; $display("FAIL div[%0d] latency: got %0d want %0d", i, c, e.lat); end
            if (bus.hi !== e.hi) begin miscompares++; $display("FAIL div[%0d] hi: got %h want %h", i, bus.hi, e.hi); end
            if (bus.lo !== e.lo) begin miscompares++; $display("FAIL div[%0d] lo: got %h want %h", i, bus.lo, e.lo); end
            mdl_hi = e.hi;
            mdl_lo = e.lo;
        end
    endtask
    task automatic test_flush();
        int seen;
        issue(MDU_DIV, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        vectors += 4;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL flush busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL flush done: got %b want 0", bus.done); end
        if (bus.hi !== mdl_hi) begin miscompares++; $display("FAIL flush hi: got %h want %h", bus.hi, mdl_hi); end
        if (bus.lo !== mdl_lo) begin miscompares++; $display("FAIL flush lo: got %h want %h", bus.lo, mdl_lo); end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        vectors++;
        if (seen != 0) begin miscompares++; $display("FAIL flush stray done: got %0d pulses want 0", seen); end
        @(negedge clk);
        bus.flush = 1'b1;
        bus.valid = 1'b1;
        bus.op = MDU_MTHI;
        bus.a = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.valid = 1'b0;
        vectors++;
        if (bus.hi !== mdl_hi) begin miscompares++; $display("FAIL flush over valid hi: got %h want %h", bus.hi, mdl_hi); end
        issue(MDU_MTLO, 32'h1234, 32'd0, 1'b0);
        mdl_lo = 32'h1234;
        vectors += 3;
        if (bus.lo !== mdl_lo) begin miscompares++; $display("FAIL mtlo lo: got %h want %h", bus.lo, mdl_lo); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mtlo busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL mtlo done: got %b want 0", bus.done); end
        issue(MDU_MTHI, 32'h0000_5678, 32'd0, 1'b0);
        mdl_hi = 32'h0000_5678;
        vectors++;
        if (bus.hi !== mdl_hi) begin miscompares++; $display("FAIL mthi hi: got %h want %h", bus.hi, mdl_hi); end
    endtask
    task automatic test_ignore();
        int   c;
        exp_t e;
        issue(MDU_DIV, 32'd100, 32'd7, 1'b1);
        bus.valid = 1'b1;
        bus.op = MDU_MTHI;
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'd0;
        repeat (20) @(posedge clk);
        #1;
        bus.valid = 1'b0;
        vectors += 2;
        if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL ignore busy: got %b want 1", bus.busy); end
        if (bus.hi !== mdl_hi) begin miscompares++; $display("FAIL ignore hi: got %h want %h", bus.hi, mdl_hi); end
        wait_done(20, c);
        e = sb.pop_front();
        vectors += 3;
        if (c !== e.lat) begin miscompares++; $display("FAIL ignore latency: got %0d want %0d", c, e.lat); end
        if (bus.hi !== e.hi) begin miscompares++; $display("FAIL ignore div hi: got %h want %h", bus.hi, e.hi); end
        if (bus.lo !== e.lo) begin miscompares++; $display("FAIL ignore div lo: got %h want %h", bus.lo, e.lo); end
        mdl_hi = e.hi;
        mdl_lo = e.lo;
    endtask
    task automatic test_back_to_back();
        mdu_op_t ops[3] = '{MDU_MULT, MDU_MULTU, MDU_DIVU};
        word_t   av[3] = '{32'd2, 32'd4, 32'd50};
        word_t   bv[3] = '{32'd3, 32'd5, 32'd7};
        int      c;
        exp_t    e;
        issue(MDU_MTHI, 32'h55, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                vectors++;
                if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b[%0d] busy on done cycle: got %b want 0", i, bus.busy); end
            end
            issue(ops[i], av[i], bv[i], 1'b1);
            wait_done(0, c);
            e = sb.pop_front();
            vectors += 3;
            if (c !== e.lat) begin miscompares++; $display("FAIL b2b[%0d] latency: got %0d want %0d", i, c, e.lat); end
            if (bus.hi !== e.hi) begin miscompares++; $display("FAIL b2b[%0d] hi: got %h want %h", i, bus.hi, e.hi); end
            if (bus.lo !== e.lo) begin miscompares++; $display("FAIL b2b[%0d] lo: got %h want %h", i, bus.lo, e.lo); end
            mdl_hi = e.hi;
            mdl_lo = e.lo;
        end
    endtask
    task automatic test_reset_mid();
        int seen;
        issue(MDU_MULT, 32'd5, 32'd6, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
        vectors += 4;
        if (bus.hi !== mdl_hi) begin miscompares++; $display("FAIL reset mid hi: got %h want %h", bus.hi, mdl_hi); end
        if (bus.lo !== mdl_lo) begin miscompares++; $display("FAIL reset mid lo: got %h want %h", bus.lo, mdl_lo); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset mid busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset mid done: got %b want 0", bus.done); end
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        vectors++;
        if (seen != 0) begin miscompares++; $display("FAIL reset mid stray done: got %0d pulses want 0", seen); end
    endtask
    initial begin
        clk = 1'b0;
        reset = 1'b1;
        vectors = 0;
        miscompares = 0;
        bus.flush = 1'b0;
        bus.valid = 1'b0;
        bus.op = MDU_MULT;
        bus.a = 32'd0;
        bus.b = 32'd0;
        test_reset();
        test_mul();
        test_div();
        test_flush();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
